// File: rtl/code_patch_pkg.sv
// Shared definitions for the code-patch engine.
//   - Default widths for fetch address, code word, patch table depth and hit counter.
//   - patch_entry_t: one table entry {en, addr, data} at the default widths.
//   - idx_width(): entry index width, never narrower than one bit.
package code_patch_pkg;

    localparam int unsigned CPE_ADDR_W    = 13;
    localparam int unsigned CPE_DATA_W    = 22;
    localparam int unsigned CPE_NUM_PATCH = 4;
    localparam int unsigned CPE_CNT_W     = 8;

    typedef struct packed {
        logic                  en;
        logic [CPE_ADDR_W-1:0] addr;
        logic [CPE_DATA_W-1:0] data;
    } patch_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/code_patch_match.sv
// Combinational patch-table lookup.
// Compares the fetch address against every enabled entry; the lowest matching index wins.
// Ports:
//   si_addr_i   fetch address
//   ent_en_i    per-entry enable
//   ent_addr_i  per-entry match address
//   ent_data_i  per-entry replacement word
//   hit_o       at least one enabled entry matches
//   idx_o       index of the winning entry (0 when no hit)
//   data_o      replacement word of the winning entry (0 when no hit)
module code_patch_match
    import code_patch_pkg::*;
#(
    parameter int unsigned ADDR_W    = CPE_ADDR_W,
    parameter int unsigned DATA_W    = CPE_DATA_W,
    parameter int unsigned NUM_PATCH = CPE_NUM_PATCH,
    parameter int unsigned IDX_W     = idx_width(NUM_PATCH)
) (
    input  logic [ADDR_W-1:0]                 si_addr_i,
    input  logic [NUM_PATCH-1:0]              ent_en_i,
    input  logic [NUM_PATCH-1:0][ADDR_W-1:0]  ent_addr_i,
    input  logic [NUM_PATCH-1:0][DATA_W-1:0]  ent_data_i,
    output logic                              hit_o,
    output logic [IDX_W-1:0]                  idx_o,
    output logic [DATA_W-1:0]                 data_o
);

    // Scan from the top down so the last assignment is the lowest matching index.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        data_o = '0;
        for (int i = NUM_PATCH - 1; i >= 0; i--) begin
            if (ent_en_i[i] && (ent_addr_i[i] == si_addr_i)) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                data_o = ent_data_i[i];
            end
        end
    end

endmodule

// File: rtl/code_patch_engine.sv
// Code-patch unit between instruction fetch and code ROM.
// Fetches are looked up in a programmable patch table; on a hit the ROM word is replaced.
// A pattern-generator mode returns a counting sequence instead (bring-up / BIST).
// Latency 2 cycles, one word per cycle, no backpressure.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   cfg_wr_i          write entry cfg_idx_i with {cfg_en_i, cfg_addr_i, cfg_data_i}
//   cfg_idx_i         entry index (out-of-range writes are dropped)
//   cfg_pat_gen_i     pattern mode, sampled with each fetch request
//   cnt_clr_i         synchronous hit-counter clear (wins over a concurrent hit)
//   si_read_i/addr_i  fetch request
//   rom_data_i        ROM word, valid the cycle after its request
//   rd_valid_o        result valid pulse
//   rd_data_o         returned word (held while rd_valid_o is low)
//   nopg_o            1 = unmodified ROM word
//   hit_idx_o         winning entry of the last patched read
//   hit_cnt_o         saturating patch-hit count
module code_patch_engine
    import code_patch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = CPE_ADDR_W,
    parameter int unsigned       DATA_W    = CPE_DATA_W,
    parameter int unsigned       NUM_PATCH = CPE_NUM_PATCH,
    parameter int unsigned       IDX_W     = idx_width(NUM_PATCH),
    parameter int unsigned       CNT_W     = CPE_CNT_W,
    parameter logic [DATA_W-1:0] PAT_SEED  = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_wr_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cfg_en_i,
    input  logic              cfg_pat_gen_i,
    input  logic              cnt_clr_i,
    input  logic              si_read_i,
    input  logic [ADDR_W-1:0] si_addr_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              nopg_o,
    output logic [IDX_W-1:0]  hit_idx_o,
    output logic [CNT_W-1:0]  hit_cnt_o
);

    // Patch table
    logic [NUM_PATCH-1:0]             r_ent_en;
    logic [NUM_PATCH-1:0][ADDR_W-1:0] r_ent_addr;
    logic [NUM_PATCH-1:0][DATA_W-1:0] r_ent_data;

    // Lookup result
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_data;

    // S1: registered lookup
    logic              r_s1_valid;
    logic              r_s1_pat;
    logic              r_s1_hit;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [DATA_W-1:0] r_s1_data;

    // S2: registered outputs and counters
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_nopg;
    logic [IDX_W-1:0]  r_hit_idx;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [DATA_W-1:0] r_pat_cnt;

    logic              w_hit_inc;

    // Table write lands at the edge, so a same-cycle lookup still sees the old contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ent_en   <= '0;
            r_ent_addr <= '0;
            r_ent_data <= '0;
        end else begin
            for (int i = 0; i < NUM_PATCH; i++) begin
                if (cfg_wr_i && (cfg_idx_i == IDX_W'(i))) begin
                    r_ent_en[i]   <= cfg_en_i;
                    r_ent_addr[i] <= cfg_addr_i;
                    r_ent_data[i] <= cfg_data_i;
                end
            end
        end
    end

    code_patch_match #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_PATCH (NUM_PATCH),
        .IDX_W     (IDX_W)
    ) u_match (
        .si_addr_i  (si_addr_i),
        .ent_en_i   (r_ent_en),
        .ent_addr_i (r_ent_addr),
        .ent_data_i (r_ent_data),
        .hit_o      (w_hit),
        .idx_o      (w_idx),
        .data_o     (w_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_pat   <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= si_read_i;
            if (si_read_i) begin
                r_s1_pat  <= cfg_pat_gen_i;
                r_s1_hit  <= w_hit;
                r_s1_idx  <= w_idx;
                r_s1_data <= w_data;
            end
        end
    end

    // Output mux: pattern beats patch beats ROM. Data/nopg/idx hold while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_nopg     <= 1'b1;
            r_hit_idx  <= '0;
            r_pat_cnt  <= PAT_SEED;
        end else begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_pat) begin
                    r_rd_data <= r_pat_cnt;
                    r_nopg    <= 1'b0;
                    r_pat_cnt <= r_pat_cnt + DATA_W'(1);
                end else if (r_s1_hit) begin
                    r_rd_data <= r_s1_data;
                    r_nopg    <= 1'b0;
                    r_hit_idx <= r_s1_idx;
                end else begin
                    r_rd_data <= rom_data_i;
                    r_nopg    <= 1'b1;
                end
            end
        end
    end

    assign w_hit_inc = r_s1_valid && !r_s1_pat && r_s1_hit && !(&r_hit_cnt);

    // Clear takes priority; a hit in the clear cycle is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_hit_cnt <= '0;
        end else if (w_hit_inc) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign nopg_o     = r_nopg;
    assign hit_idx_o  = r_hit_idx;
    assign hit_cnt_o  = r_hit_cnt;

endmodule

// File: tb/tb_code_patch_engine.sv
// Directed bench for code_patch_engine (NUM_PATCH=3 so index 3 is out of range,
// CNT_W=2 for saturation, PAT_SEED near the wrap point).
module tb_code_patch_engine;

    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DATA_W    = 22;
    localparam int unsigned NUM_PATCH = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 2;
    localparam logic [DATA_W-1:0] SEED = 22'h3FFFFE;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cfg_wr_i;
    logic [IDX_W-1:0]  cfg_idx_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [DATA_W-1:0] cfg_data_i;
    logic              cfg_en_i;
    logic              cfg_pat_gen_i;
    logic              cnt_clr_i;
    logic              si_read_i;
    logic [ADDR_W-1:0] si_addr_i;
    logic [DATA_W-1:0] rom_data_i = '0;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              nopg_o;
    logic [IDX_W-1:0]  hit_idx_o;
    logic [CNT_W-1:0]  hit_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    code_patch_engine #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_PATCH (NUM_PATCH),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W),
        .PAT_SEED  (SEED)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cfg_wr_i      (cfg_wr_i),
        .cfg_idx_i     (cfg_idx_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_data_i    (cfg_data_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_pat_gen_i (cfg_pat_gen_i),
        .cnt_clr_i     (cnt_clr_i),
        .si_read_i     (si_read_i),
        .si_addr_i     (si_addr_i),
        .rom_data_i    (rom_data_i),
        .rd_valid_o    (rd_valid_o),
        .rd_data_o     (rd_data_o),
        .nopg_o        (nopg_o),
        .hit_idx_o     (hit_idx_o),
        .hit_cnt_o     (hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM model: word depends on the address requested in the previous cycle.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {9'h155, a};
    endfunction

    always @(posedge clk_i) rom_data_i <= rom_word(si_addr_i);

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [DATA_W-1:0] exp_data,
                            input logic exp_nopg);
        check({tag, ".valid"}, 32'(rd_valid_o), 32'd1);
        check({tag, ".data"},  32'(rd_data_o),  32'(exp_data));
        check({tag, ".nopg"},  32'(nopg_o),     32'(exp_nopg));
    endtask

    task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic en);
        cfg_wr_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_addr_i = addr;
        cfg_data_i = data;
        cfg_en_i   = en;
        tick();
        cfg_wr_i   = 1'b0;
    endtask

    task automatic read(input logic [ADDR_W-1:0] addr);
        si_read_i = 1'b1;
        si_addr_i = addr;
    endtask

    initial begin
        rst_ni        = 1'b0;
        cfg_wr_i      = 1'b0;
        cfg_idx_i     = '0;
        cfg_addr_i    = '0;
        cfg_data_i    = '0;
        cfg_en_i      = 1'b0;
        cfg_pat_gen_i = 1'b0;
        cnt_clr_i     = 1'b0;
        si_read_i     = 1'b0;
        si_addr_i     = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Reset values
        check("rst.valid", 32'(rd_valid_o), 32'd0);
        check("rst.data",  32'(rd_data_o),  32'd0);
        check("rst.nopg",  32'(nopg_o),     32'd1);
        check("rst.idx",   32'(hit_idx_o),  32'd0);
        check("rst.cnt",   32'(hit_cnt_o),  32'd0);

        // 1. Reset mid-stream with reads in flight
        read(13'h0010); tick();
        read(13'h0011); tick();
        read(13'h0012);
        #1 rst_ni = 1'b0;
        #1 check("midrst.async_valid", 32'(rd_valid_o), 32'd0);
        si_read_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst.no_valid", 32'(rd_valid_o), 32'd0);
        end
        check("midrst.nopg", 32'(nopg_o),    32'd1);
        check("midrst.cnt",  32'(hit_cnt_o), 32'd0);
        // Cleared entries hold addr 0 but are disabled, so address 0 reads ROM.
        read(13'h0000); tick();
        si_read_i = 1'b0; tick();
        check_rd("midrst.empty", rom_word(13'h0000), 1'b1);

        // 2. Single patch, back-to-back reads around it
        cfg_write(2'd1, 13'h0040, 22'h3ABCDE, 1'b1);
        read(13'h003F); tick();
        read(13'h0040); tick();
        check_rd("t2.r0", rom_word(13'h003F), 1'b1);
        read(13'h0041); tick();
        check_rd("t2.r1", 22'h3ABCDE, 1'b0);
        check("t2.idx", 32'(hit_idx_o), 32'd1);
        check("t2.cnt", 32'(hit_cnt_o), 32'd1);
        si_read_i = 1'b0; tick();
        check_rd("t2.r2", rom_word(13'h0041), 1'b1);
        check("t2.idx_hold", 32'(hit_idx_o), 32'd1);
        tick();
        check("t2.idle_valid", 32'(rd_valid_o), 32'd0);
        check("t2.idle_data",  32'(rd_data_o),  32'(rom_word(13'h0041)));

        // 3. Priority between overlapping entries, then disable the winner
        cfg_write(2'd0, 13'h0100, 22'h111111, 1'b1);
        cfg_write(2'd2, 13'h0100, 22'h222222, 1'b1);
        read(13'h0100); tick();
        si_read_i = 1'b0; tick();
        check_rd("t3.prio", 22'h111111, 1'b0);
        check("t3.prio_idx", 32'(hit_idx_o), 32'd0);
        cfg_write(2'd0, 13'h0100, 22'h111111, 1'b0);
        read(13'h0100); tick();
        si_read_i = 1'b0; tick();
        check_rd("t3.dis", 22'h222222, 1'b0);
        check("t3.dis_idx", 32'(hit_idx_o), 32'd2);
        check("t3.cnt",     32'(hit_cnt_o), 32'd3);

        // 4. Write and lookup in the same cycle
        read(13'h0200);
        cfg_write(2'd0, 13'h0200, 22'h0ABCDE, 1'b1);
        read(13'h0200); tick();
        check_rd("t4.same", rom_word(13'h0200), 1'b1);
        si_read_i = 1'b0; tick();
        check_rd("t4.next", 22'h0ABCDE, 1'b0);
        check("t4.idx",     32'(hit_idx_o), 32'd0);
        check("t4.cnt_sat", 32'(hit_cnt_o), 32'd3);

        // Out-of-range index write is ignored
        cfg_write(2'd3, 13'h0300, 22'h333333, 1'b1);
        read(13'h0300); tick();
        si_read_i = 1'b0; tick();
        check_rd("oor", rom_word(13'h0300), 1'b1);

        cnt_clr_i = 1'b1; tick();
        cnt_clr_i = 1'b0;
        check("clr.cnt", 32'(hit_cnt_o), 32'd0);

        // 5. Pattern mode wraps; address 0x200 would hit but must not count
        cfg_pat_gen_i = 1'b1;
        read(13'h0200); tick();
        read(13'h0200); tick();
        check_rd("t5.p0", 22'h3FFFFE, 1'b0);
        read(13'h0200); tick();
        check_rd("t5.p1", 22'h3FFFFF, 1'b0);
        cfg_pat_gen_i = 1'b0;
        read(13'h0200); tick();
        check_rd("t5.p2", 22'h000000, 1'b0);
        check("t5.cnt", 32'(hit_cnt_o), 32'd0);
        si_read_i = 1'b0; tick();
        check_rd("t5.leave", 22'h0ABCDE, 1'b0);
        check("t5.cnt1", 32'(hit_cnt_o), 32'd1);

        // 6. Saturation at 3, then clear together with a hit
        read(13'h0200); tick();
        read(13'h0200); tick();
        check("t6.c2", 32'(hit_cnt_o), 32'd2);
        read(13'h0200); tick();
        check("t6.c3", 32'(hit_cnt_o), 32'd3);
        read(13'h0200); tick();
        check("t6.c4", 32'(hit_cnt_o), 32'd3);
        si_read_i = 1'b0; tick();
        check("t6.c5", 32'(hit_cnt_o), 32'd3);
        read(13'h0200); tick();
        si_read_i = 1'b0;
        cnt_clr_i = 1'b1; tick();
        cnt_clr_i = 1'b0;
        check_rd("t6.clrhit", 22'h0ABCDE, 1'b0);
        check("t6.clrhit_cnt", 32'(hit_cnt_o), 32'd0);
        tick();
        check("t6.after_clr", 32'(hit_cnt_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
